// File: rtl/rf_hazard_scoreboard.sv
// Hazard scoreboard for the 5-stage MIPS pipeline.
// Tracks in-flight destination registers through shadow E/M/W stages with
// their remaining result latency (tnew), and compares them with the operand
// need time (tuse) of the instruction in D. It drives the D-stage stall and
// the forwarding-mux selects for the D, E and M consumers.
// Shadow stage numbering: _p0 = E, _p1 = M, _p2 = W.
module rf_hazard_scoreboard #(
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ir_d,
  output logic        stall,
  output logic [1:0]  fwd_rs_d,
  output logic [1:0]  fwd_rt_d,
  output logic [1:0]  fwd_rs_e,
  output logic [1:0]  fwd_rt_e,
  output logic        fwd_rt_m
);

  // Link register written by jal is the top architectural register.
  localparam logic [AW-1:0] RA_REG = AW'(NREG - 1);

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_LW      = 6'b100011;
  localparam logic [5:0] OP_SW      = 6'b101011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_LUI     = 6'b001111;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] FN_ADDU    = 6'b100001;
  localparam logic [5:0] FN_SUBU    = 6'b100011;
  localparam logic [5:0] FN_JR      = 6'b001000;

  // Operand addresses are zeroed when the instruction does not read them,
  // so register 0 doubles as "no operand" and can never match a stage.
  typedef struct packed {
    logic          dv;
    logic [AW-1:0] a3;
    logic [1:0]    tnew;
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    logic [1:0]    tuse_rs;
    logic [1:0]    tuse_rt;
  } dec_t;

  function automatic dec_t decode(input logic [5:0]    op,
                                  input logic [5:0]    funct,
                                  input logic [AW-1:0] rs,
                                  input logic [AW-1:0] rt,
                                  input logic [AW-1:0] rd);
    dec_t d;
    d = '0;
    case (op)
      OP_SPECIAL: begin
        if (funct == FN_ADDU || funct == FN_SUBU) begin
          d.dv      = 1'b1;
          d.a3      = rd;
          d.tnew    = 2'd1;
          d.rs      = rs;
          d.rt      = rt;
          d.tuse_rs = 2'd1;
          d.tuse_rt = 2'd1;
        end else if (funct == FN_JR) begin
          d.rs      = rs;
          d.tuse_rs = 2'd0;
        end
      end
      OP_ORI, OP_LUI, OP_LW: begin
        d.dv      = 1'b1;
        d.a3      = rt;
        d.tnew    = (op == OP_LW) ? 2'd2 : 2'd1;
        d.rs      = rs;
        d.tuse_rs = 2'd1;
      end
      OP_SW: begin
        d.rs      = rs;
        d.rt      = rt;
        d.tuse_rs = 2'd1;
        d.tuse_rt = 2'd2;
      end
      OP_BEQ: begin
        d.rs      = rs;
        d.rt      = rt;
        d.tuse_rs = 2'd0;
        d.tuse_rt = 2'd0;
      end
      OP_JAL: begin
        d.dv   = 1'b1;
        d.a3   = RA_REG;
        d.tnew = 2'd0;
      end
      default: ;
    endcase
    // A write to register 0 is discarded, so it is not tracked.
    if (d.a3 == '0) d.dv = 1'b0;
    return d;
  endfunction

  function automatic logic [1:0] tnew_dec(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

  function automatic logic hit(input logic          v,
                               input logic [AW-1:0] a3,
                               input logic [AW-1:0] r);
    return v && (a3 == r) && (r != '0);
  endfunction

  dec_t          dec_d;
  logic          unused_shamt;

  logic          vld_p0, vld_p1, vld_p2;
  logic [AW-1:0] a3_p0, a3_p1, a3_p2;
  logic [1:0]    tnew_p0, tnew_p1, tnew_p2;
  logic [AW-1:0] rs_p0, rt_p0, rt_p1;

  assign unused_shamt = ^ir_d[10:6];

  // Decode the instruction sitting in D.
  always_comb begin
    dec_d = decode(ir_d[31:26], ir_d[5:0], AW'(ir_d[25:21]),
                   AW'(ir_d[20:16]), AW'(ir_d[15:11]));
  end

  // Stall when an E or M producer cannot deliver before the D operand is needed.
  always_comb begin
    stall = (hit(vld_p0, a3_p0, dec_d.rs) && (tnew_p0 > dec_d.tuse_rs)) ||
            (hit(vld_p1, a3_p1, dec_d.rs) && (tnew_p1 > dec_d.tuse_rs)) ||
            (hit(vld_p0, a3_p0, dec_d.rt) && (tnew_p0 > dec_d.tuse_rt)) ||
            (hit(vld_p1, a3_p1, dec_d.rt) && (tnew_p1 > dec_d.tuse_rt));
  end

  // D-stage forwarding: youngest matching stage wins; not ready yet gives RF.
  always_comb begin
    fwd_rs_d = 2'd0;
    if (hit(vld_p0, a3_p0, dec_d.rs))      fwd_rs_d = (tnew_p0 == 2'd0) ? 2'd1 : 2'd0;
    else if (hit(vld_p1, a3_p1, dec_d.rs)) fwd_rs_d = (tnew_p1 == 2'd0) ? 2'd2 : 2'd0;
    else if (hit(vld_p2, a3_p2, dec_d.rs)) fwd_rs_d = (tnew_p2 == 2'd0) ? 2'd3 : 2'd0;

    fwd_rt_d = 2'd0;
    if (hit(vld_p0, a3_p0, dec_d.rt))      fwd_rt_d = (tnew_p0 == 2'd0) ? 2'd1 : 2'd0;
    else if (hit(vld_p1, a3_p1, dec_d.rt)) fwd_rt_d = (tnew_p1 == 2'd0) ? 2'd2 : 2'd0;
    else if (hit(vld_p2, a3_p2, dec_d.rt)) fwd_rt_d = (tnew_p2 == 2'd0) ? 2'd3 : 2'd0;
  end

  // E-stage and M-stage forwarding for the instruction operands carried along.
  always_comb begin
    fwd_rs_e = 2'd0;
    if (hit(vld_p1, a3_p1, rs_p0) && (tnew_p1 == 2'd0)) fwd_rs_e = 2'd2;
    else if (hit(vld_p2, a3_p2, rs_p0))                 fwd_rs_e = 2'd3;

    fwd_rt_e = 2'd0;
    if (hit(vld_p1, a3_p1, rt_p0) && (tnew_p1 == 2'd0)) fwd_rt_e = 2'd2;
    else if (hit(vld_p2, a3_p2, rt_p0))                 fwd_rt_e = 2'd3;

    fwd_rt_m = hit(vld_p2, a3_p2, rt_p1);
  end

  // Stage valids: reset clears all, a stall turns the E entry into a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      vld_p0 <= dec_d.dv && !stall;
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
    end
  end

  // Stage payload advances every cycle; tnew counts down and saturates at 0.
  always_ff @(posedge clk) begin
    // D -> E
    a3_p0   <= dec_d.a3;
    tnew_p0 <= dec_d.tnew;
    rs_p0   <= stall ? '0 : dec_d.rs;
    rt_p0   <= stall ? '0 : dec_d.rt;
    // E -> M
    a3_p1   <= a3_p0;
    tnew_p1 <= tnew_dec(tnew_p0);
    rt_p1   <= rt_p0;
    // M -> W
    a3_p2   <= a3_p1;
    tnew_p2 <= tnew_dec(tnew_p1);
  end

endmodule

// File: tb/tb_rf_hazard_scoreboard.sv
// Self-checking bench for rf_hazard_scoreboard: directed hazard scenarios
// followed by a randomized instruction stream, all compared against an
// age-indexed reference model of the in-flight instructions.
module tb_rf_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ir_d;
  logic        stall;
  logic [1:0]  fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;
  logic        fwd_rt_m;

  always #5 clk = ~clk;

  rf_hazard_scoreboard #(.NREG(32), .AW(5)) dut (
    .clk      (clk),
    .reset    (reset),
    .ir_d     (ir_d),
    .stall    (stall),
    .fwd_rs_d (fwd_rs_d),
    .fwd_rt_d (fwd_rt_d),
    .fwd_rs_e (fwd_rs_e),
    .fwd_rt_e (fwd_rt_e),
    .fwd_rt_m (fwd_rt_m)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- instruction builders ----------------
  function automatic logic [31:0] r_type(input int rs, input int rt, input int rd, input logic [5:0] fn);
    return {6'b000000, 5'(rs), 5'(rt), 5'(rd), 5'b00000, fn};
  endfunction
  function automatic logic [31:0] i_type(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction
  function automatic logic [31:0] j_type(input logic [5:0] op);
    return {op, 26'h0000040};
  endfunction

  localparam logic [31:0] NOP = 32'h0;

  // ---------------- reference model ----------------
  // One entry per instruction that entered E; age 0 = E, 1 = M, 2 = W.
  typedef struct {
    bit v;      // writes a tracked register
    int dest;
    int tnew0;  // latency to result when entering E
    int rs;     // 0 when not read
    int rt;
    int tu_rs;
    int tu_rt;
  } inst_t;

  inst_t age[3];
  bit    last_stall;

  function automatic inst_t dec(input logic [31:0] ir);
    inst_t d;
    int op, fn, rs, rt, rd;
    op = int'(ir[31:26]); fn = int'(ir[5:0]);
    rs = int'(ir[25:21]); rt = int'(ir[20:16]); rd = int'(ir[15:11]);
    d = '{v:0, dest:0, tnew0:0, rs:0, rt:0, tu_rs:0, tu_rt:0};
    if (op == 0 && (fn == 'h21 || fn == 'h23)) d = '{1, rd, 1, rs, rt, 1, 1};
    else if (op == 0 && fn == 'h08)           d = '{0, 0, 0, rs, 0, 0, 0};
    else if (op == 'h0D || op == 'h0F)        d = '{1, rt, 1, rs, 0, 1, 0};
    else if (op == 'h23)                      d = '{1, rt, 2, rs, 0, 1, 0};
    else if (op == 'h2B)                      d = '{0, 0, 0, rs, rt, 1, 2};
    else if (op == 'h04)                      d = '{0, 0, 0, rs, rt, 0, 0};
    else if (op == 'h03)                      d = '{1, 31, 0, 0, 0, 0, 0};
    if (d.dest == 0) d.v = 0;
    return d;
  endfunction

  function automatic int remaining(input int k);
    return (age[k].tnew0 - k > 0) ? age[k].tnew0 - k : 0;
  endfunction

  function automatic bit writes(input int k, input int r);
    return age[k].v && age[k].dest == r && r != 0;
  endfunction

  function automatic bit model_stall(input inst_t d);
    bit s = 0;
    for (int k = 0; k < 2; k++) begin
      if (writes(k, d.rs) && remaining(k) > d.tu_rs) s = 1;
      if (writes(k, d.rt) && remaining(k) > d.tu_rt) s = 1;
    end
    return s;
  endfunction

  function automatic int model_fwd_d(input int r);
    for (int k = 0; k < 3; k++)
      if (writes(k, r)) return (remaining(k) == 0) ? k + 1 : 0;
    return 0;
  endfunction

  function automatic int model_fwd_e(input int r);
    if (writes(1, r) && remaining(1) == 0) return 2;
    if (writes(2, r)) return 3;
    return 0;
  endfunction

  function automatic void model_clear();
    for (int k = 0; k < 3; k++) age[k] = '{v:0, dest:0, tnew0:0, rs:0, rt:0, tu_rs:0, tu_rt:0};
  endfunction

  // Apply inputs for this cycle and compare all outputs mid-cycle.
  task automatic present(input logic [31:0] ir, input logic rst);
    inst_t d;
    ir_d  = ir;
    reset = rst;
    @(negedge clk);
    d = dec(ir);
    last_stall = model_stall(d);
    check("stall",    stall,    last_stall);
    check("fwd_rs_d", fwd_rs_d, model_fwd_d(d.rs));
    check("fwd_rt_d", fwd_rt_d, model_fwd_d(d.rt));
    check("fwd_rs_e", fwd_rs_e, model_fwd_e(age[0].rs));
    check("fwd_rt_e", fwd_rt_e, model_fwd_e(age[0].rt));
    check("fwd_rt_m", fwd_rt_m, writes(2, age[1].rt));
  endtask

  // Clock edge: age the model the same way the pipeline moves.
  task automatic advance();
    @(posedge clk);
    if (reset) model_clear();
    else begin
      age[2] = age[1];
      age[1] = age[0];
      if (last_stall) age[0] = '{v:0, dest:0, tnew0:0, rs:0, rt:0, tu_rs:0, tu_rt:0};
      else            age[0] = dec(ir_d);
    end
    #1;
  endtask

  // Hold an instruction in D until it is allowed to enter E.
  task automatic issue(input logic [31:0] ir);
    int n = 0;
    present(ir, 1'b0);
    while (last_stall && n < 4) begin
      advance();
      present(ir, 1'b0);
      n++;
    end
    if (last_stall) check("stall_bound", stall, 1'b0);
    advance();
  endtask

  task automatic flush();
    repeat (3) begin
      present(NOP, 1'b0);
      advance();
    end
  endtask

  function automatic int rreg();
    int r = $urandom_range(0, 4);
    return (r == 4) ? 31 : r;
  endfunction

  function automatic logic [31:0] rnd_inst();
    case ($urandom_range(0, 11))
      0:  return r_type(rreg(), rreg(), rreg(), 6'h21);
      1:  return r_type(rreg(), rreg(), rreg(), 6'h23);
      2:  return i_type(6'h0D, rreg(), rreg(), 16'(int'($urandom)));
      3:  return i_type(6'h23, rreg(), rreg(), 16'h0004);
      4:  return i_type(6'h2B, rreg(), rreg(), 16'h0008);
      5:  return i_type(6'h04, rreg(), rreg(), 16'hFFFC);
      6:  return i_type(6'h0F, rreg(), rreg(), 16'h1234);
      7:  return j_type(6'h02);
      8:  return j_type(6'h03);
      9:  return r_type(rreg(), 0, 0, 6'h08);
      10: return NOP;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset = 1'b1;
    ir_d  = NOP;
    last_stall = 0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    present(NOP, 1'b1);
    check("rst_stall", stall, 1'b0);
    check("rst_fwd_rs_e", fwd_rs_e, 2'd0);
    advance();

    // lw $1 ; addu $2,$1,$1 : one stall cycle, then W forwarding in E
    present(i_type(6'h23, 0, 1, 16'h0), 1'b0); advance();
    present(r_type(1, 1, 2, 6'h21), 1'b0);
    check("lwuse_stall_c1", stall, 1'b1); advance();
    present(r_type(1, 1, 2, 6'h21), 1'b0);
    check("lwuse_stall_c2", stall, 1'b0); advance();
    present(NOP, 1'b0);
    check("lwuse_fwd_rs_e", fwd_rs_e, 2'd3);
    check("lwuse_fwd_rt_e", fwd_rt_e, 2'd3); advance();
    flush();

    // ori $3,$0,5 ; beq $3,$3 : one stall, then M forwarding in D
    present(i_type(6'h0D, 0, 3, 16'd5), 1'b0); advance();
    present(i_type(6'h04, 3, 3, 16'h0), 1'b0);
    check("oribeq_stall", stall, 1'b1); advance();
    present(i_type(6'h04, 3, 3, 16'h0), 1'b0);
    check("oribeq_go", stall, 1'b0);
    check("oribeq_fwd_rs_d", fwd_rs_d, 2'd2);
    check("oribeq_fwd_rt_d", fwd_rt_d, 2'd2); advance();
    flush();

    // lw $4 ; beq $4,$0 : two stall cycles, then W forwarding in D
    present(i_type(6'h23, 0, 4, 16'h0), 1'b0); advance();
    present(i_type(6'h04, 4, 0, 16'h0), 1'b0);
    check("lwbeq_stall1", stall, 1'b1); advance();
    present(i_type(6'h04, 4, 0, 16'h0), 1'b0);
    check("lwbeq_stall2", stall, 1'b1); advance();
    present(i_type(6'h04, 4, 0, 16'h0), 1'b0);
    check("lwbeq_go", stall, 1'b0);
    check("lwbeq_fwd_rs_d", fwd_rs_d, 2'd3); advance();
    flush();

    // jal ; jr $31 : pc+8 forwarded from E
    present(j_type(6'h03), 1'b0); advance();
    present(r_type(31, 0, 0, 6'h08), 1'b0);
    check("jaljr_stall", stall, 1'b0);
    check("jaljr_fwd_rs_d", fwd_rs_d, 2'd1); advance();
    flush();

    // addu $5 ; sw $5 : store data from M in E
    present(r_type(1, 2, 5, 6'h21), 1'b0); advance();
    present(i_type(6'h2B, 0, 5, 16'h0), 1'b0);
    check("addusw_stall", stall, 1'b0); advance();
    present(NOP, 1'b0);
    check("addusw_fwd_rt_e", fwd_rt_e, 2'd2); advance();
    flush();

    // lw $6 ; sw $6 : no stall, store data from W in M
    present(i_type(6'h23, 0, 6, 16'h0), 1'b0); advance();
    present(i_type(6'h2B, 0, 6, 16'h0), 1'b0);
    check("lwsw_stall", stall, 1'b0); advance();
    present(NOP, 1'b0); advance();
    present(NOP, 1'b0);
    check("lwsw_fwd_rt_m", fwd_rt_m, 1'b1); advance();
    flush();

    // ori $0 ; addu $2,$0,$0 : register 0 is never tracked
    present(i_type(6'h0D, 0, 0, 16'd7), 1'b0); advance();
    present(r_type(0, 0, 2, 6'h21), 1'b0);
    check("r0_stall", stall, 1'b0);
    check("r0_fwd_rs_d", fwd_rs_d, 2'd0);
    check("r0_fwd_rt_d", fwd_rt_d, 2'd0); advance();
    present(NOP, 1'b0);
    check("r0_fwd_rs_e", fwd_rs_e, 2'd0); advance();
    flush();

    // Reset during a lw-use stall
    present(i_type(6'h23, 0, 1, 16'h0), 1'b0); advance();
    present(r_type(1, 1, 2, 6'h21), 1'b1);
    check("rststall_before", stall, 1'b1); advance();
    present(r_type(1, 1, 2, 6'h21), 1'b0);
    check("rststall_after", stall, 1'b0);
    check("rststall_fwd_rs_d", fwd_rs_d, 2'd0); advance();
    present(NOP, 1'b0);
    check("rststall_fwd_rs_e", fwd_rs_e, 2'd0); advance();
    flush();

    // Randomized instruction stream with occasional resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        present(rnd_inst(), 1'b1);
        advance();
      end else begin
        issue(rnd_inst());
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/rf_hazard_scoreboard.md
Name: rf_hazard_scoreboard

Overview:
- Hazard controller sequencing register-file access in the 5-stage MIPS pipeline (F/D/E/M/W).
- Keeps a shadow pipeline of in-flight destination registers with remaining-latency counters (Tnew).
- Compares these against operand-need times (Tuse) of the instruction in D.
- Outputs the D-stage stall/bubble control and the forwarding-mux selects for D, E and M consumers, so no register read ever returns stale data.

Parameters:
- NREG, 32, number of architectural registers; register 0 is hard-wired zero and never tracked.
- AW, 5, register address width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high; clears all shadow-stage state.
- ir_d  input  32  instruction currently in D.
- stall  output  1  1 = hold PC and F/D register, inject bubble into E.
- fwd_rs_d  output  2  select for D-stage rs (branch/jr compare): 0 RF, 1 E (pc+8), 2 M, 3 W.
- fwd_rt_d  output  2  same encoding for D-stage rt.
- fwd_rs_e  output  2  select for ALU operand A in E: 0 pipeline reg, 2 M, 3 W (1 unused).
- fwd_rt_e  output  2  same for ALU operand B / store data in E.
- fwd_rt_m  output  1  select for store data in M: 0 pipeline reg, 1 W.

Behaviour:
- Decoded set: addu, subu (op 000000, funct 100001/100011), ori 001101, lw 100011, sw 101011, beq 000100, lui 001111, j 000010, jal 000011, jr (op 0, funct 001000). Anything else = nop: no dest, no uses.
- Destination: rd for addu/subu; rt for ori/lw/lui; 31 for jal; none otherwise. A dest of 0 is recorded as invalid.
- Tnew at entry to E: addu/subu/ori/lui = 1; lw = 2; jal = 0.
- Tuse:
  - beq rs/rt = 0; jr rs = 0.
  - addu/subu rs/rt = 1; ori/lw/lui rs = 1.
  - sw rs = 1, rt = 2.
- Shadow stages E, M, W each hold {valid, a3, tnew, rs, rt}; rs and rt are held in E and M only. Each stage is a register and advances every cycle.
- When stall=0: E <= decode(ir_d).
- When stall=1: E <= bubble (valid=0). D itself is never modified here.
- M <= E with tnew = max(E.tnew-1, 0). W <= M with tnew = max(M.tnew-1, 0). Saturation at 0 is required.
- A stage matches an operand when valid && a3 == operand && operand != 0.
- Stall (combinational from ir_d and stage state): asserted if any D operand with Tuse matches stage X (E or M) with X.tnew > Tuse. W never stalls.
- D-forwarding, priority E > M > W, taking the first matching stage:
  - E qualifies only when E.tnew == 0 (jal), giving 1.
  - M with tnew 0 gives 2; W gives 3.
  - A youngest match that is not yet ready gives 0; stall covers this case.
- E-forwarding, priority M > W: M match with M.tnew == 0 gives 2; else W match gives 3; else 0.
- M-forwarding: W match on M.rt gives 1.
- Register 0: never stalls, always selects 0.
- Reset: all valid = 0 at the next edge. Outputs after reset: stall=0 and all fwd=0, unless the reset-cycle ir_d itself decodes with no matches, which yields the same values. Reset mid-stall wins: bubbles everywhere.
- Outputs are combinational from registered state plus ir_d. There is no added latency.
- Stall for lw-use lasts exactly 1 cycle (ALU consumer) or 2 cycles (beq/jr consumer).

Test Plan:
- lw $1,0($0) then addu $2,$1,$1 → stall=1 for exactly one cycle. Next cycle stall=0, fwd_rs_e=3, fwd_rt_e=3.
- ori $3,$0,5 then beq $3,$3 → one stall cycle. Then fwd_rs_d=2, fwd_rt_d=2.
- lw $4 then beq $4,$0 → stall held 2 cycles. Third cycle fwd_rs_d=3.
- jal then jr $31 → stall=0, fwd_rs_d=1.
- addu $5,… then sw $5,0($0): E has no stall and fwd_rt_e=2. lw $6 then sw $6,0($0): no stall, fwd_rt_m=1 when sw is in M.
- ori $0,$0,7 then addu $2,$0,$0 → stall=0, all fwd=0.
- Assert reset during a lw-use stall → next cycle stall=0 and all stage valids cleared; no forward to stale a3.
